user_input_conditioner: RTL and testbench

USER_INPUT_CONDITIONER -- requirements
Module: user_input_conditioner

---
 rtl/uic_pkg.sv | 28 ++
 rtl/uic_debounce.sv | 60 ++++++
 rtl/user_input_conditioner.sv | 68 ++++++
 tb/tb_user_input_conditioner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uic_pkg.sv
// Shared types and constants for the user input conditioner.
// The optional input synchronizer is enabled by defining UIC_SYNC_EN.
package uic_pkg;

  localparam int CODE_W = 3;  // number of buttons and width of the command code
  localparam int CNT_W  = 8;  // width of press_cnt and of each debounce counter

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } uic_state_e;

  // Command code is the index of the lowest pressed button plus one; 0 if none.
  function automatic logic [CODE_W-1:0] lowest_code(input logic [CODE_W-1:0] v);
    lowest_code = '0;
    for (int i = CODE_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_code = CODE_W'(i + 1);
    end
  endfunction

  // True when two or more buttons are pressed together.
  function automatic logic multi_set(input logic [CODE_W-1:0] v);
    return $countones(v) > 1;
  endfunction

endpackage

// File: rtl/uic_debounce.sv
// One-bit button conditioner: optional 2-flop synchronizer (UIC_SYNC_EN)
// followed by a counting debouncer that accepts a change after DEB_CYCLES
// consecutive samples disagreeing with the current stable level.
module uic_debounce
  import uic_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic sample;

`ifdef UIC_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer to tame metastability on the asynchronous line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync_q2 take the old sync_q1, giving a real 2-stage shift.
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = raw;
`endif

  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sample == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      stable_q <= ~stable_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/user_input_conditioner.sv
// Debounces three raw buttons and turns each press into one command code
// with a single-cycle strobe, a saturating press counter and a sticky
// multi-button error flag. Define UIC_SYNC_EN to add input synchronizers.
module user_input_conditioner
  import uic_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] raw_btn,
  output logic [CODE_W-1:0] user_input,
  output logic              cmd_strobe,
  output logic              err_multi,
  output logic [CNT_W-1:0]  press_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CODE_W-1:0] stable_vec;
  uic_state_e        state;

  for (genvar i = 0; i < CODE_W; i++) begin : g_deb
    uic_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_btn[i]),
      .stable (stable_vec[i])
    );
  end

  // Command FSM with registered outputs; a press is captured once and the
  // buttons are locked out until every one of them is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      user_input <= '0;
      cmd_strobe <= 1'b0;
      err_multi  <= 1'b0;
      press_cnt  <= '0;
    end else begin
      cmd_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (stable_vec != '0) begin
            state      <= PRESS;
            user_input <= lowest_code(stable_vec);
            cmd_strobe <= 1'b1;
            if (press_cnt != CNT_MAX) press_cnt <= press_cnt + CNT_W'(1);
            if (multi_set(stable_vec)) err_multi <= 1'b1;
          end
        end
        PRESS: state <= HOLD;
        HOLD: begin
          if (stable_vec == '0) begin
            state      <= RELEASE;
            user_input <= '0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_input_conditioner.sv
// Self-checking bench for user_input_conditioner: directed scenarios plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_user_input_conditioner;

  localparam int DEB = 4;
`ifdef UIC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT  = SYNC + DEB + 1;  // raw change to strobe, in edges
  localparam int HALF = DEB + SYNC + 1;  // half of the minimum command period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw_btn = 3'b000;
  logic [2:0] user_input;
  logic       cmd_strobe;
  logic       err_multi;
  logic [7:0] press_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  user_input_conditioner #(
    .DEB_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_btn    (raw_btn),
    .user_input (user_input),
    .cmd_strobe (cmd_strobe),
    .err_multi  (err_multi),
    .press_cnt  (press_cnt)
  );

  // ---------------- behavioural reference model ----------------
  // Debounce: a button's accepted level flips once the last DEB samples it
  // saw all disagree with that level. Commands: one per press episode, which
  // starts when any button becomes accepted while idle and ends one cycle
  // after all buttons are accepted as released.
  logic [2:0] m_s1, m_s2;
  logic [2:0] m_stab;
  logic [2:0] win[$];
  int         m_phase;   // 0 idle, 1 just pressed, 2 holding, 3 releasing
  logic [2:0] m_ui;
  logic       m_strobe;
  logic       m_err;
  logic [7:0] m_cnt;

  task automatic tick();
    logic [2:0] din;
    logic [2:0] flip;
    logic       all_diff;
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; win.delete();
      m_phase = 0; m_ui = '0; m_strobe = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else begin
      din  = (SYNC != 0) ? m_s2 : raw_btn;
      m_s2 = m_s1;
      m_s1 = raw_btn;
      m_strobe = 1'b0;
      case (m_phase)
        0: if (m_stab != 3'b000) begin
             m_phase  = 1;
             m_strobe = 1'b1;
             m_ui     = m_stab[0] ? 3'd1 : (m_stab[1] ? 3'd2 : 3'd3);
             if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
             if (int'(m_stab[0]) + int'(m_stab[1]) + int'(m_stab[2]) >= 2) m_err = 1'b1;
           end
        1: m_phase = 2;
        2: if (m_stab == 3'b000) begin m_phase = 3; m_ui = 3'd0; end
        default: m_phase = 0;
      endcase
      win.push_back(din);
      if (win.size() > DEB) void'(win.pop_front());
      flip = '0;
      for (int i = 0; i < 3; i++) begin
        all_diff = (win.size() == DEB);
        foreach (win[k]) if (win[k][i] == m_stab[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
      if (flip != 3'b000) begin
        m_stab = m_stab ^ flip;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (user_input !== 3'd0 || cmd_strobe !== 1'b0 || err_multi !== 1'b0 || press_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_state: got ui=%0d strobe=%0b err=%0b cnt=%0d, want all 0",
               user_input, cmd_strobe, err_multi, press_cnt);
    end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_press();
    int first = -1;
    int nstb  = 0;
    logic [2:0] ui_at = '0;
    raw_btn = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (cmd_strobe === 1'b1) begin
        nstb++;
        if (first < 0) begin first = k; ui_at = user_input; end
      end
    end
    n_cmp++;
    if (first !== LAT) begin n_bad++; $display("FAIL press_latency: got %0d edges, want %0d", first, LAT); end
    n_cmp++;
    if (nstb !== 1) begin n_bad++; $display("FAIL press_strobes: got %0d, want 1", nstb); end
    n_cmp++;
    if (ui_at !== 3'd1) begin n_bad++; $display("FAIL press_code: got %0d, want 1", ui_at); end
    n_cmp++;
    if (press_cnt !== 8'd1) begin n_bad++; $display("FAIL press_cnt: got %0d, want 1", press_cnt); end
    raw_btn = 3'b000;
    repeat (20) tick();
  endtask

  task automatic test_glitch();
    int nstb = 0;
    int ui_nz = 0;
    raw_btn = 3'b010;
    for (int k = 0; k < 23; k++) begin
      if (k == 3) raw_btn = 3'b000;
      tick();
      if (cmd_strobe !== 1'b0) nstb++;
      if (user_input !== 3'd0) ui_nz++;
    end
    n_cmp++;
    if (nstb !== 0) begin n_bad++; $display("FAIL glitch_strobe: got %0d strobes, want 0", nstb); end
    n_cmp++;
    if (ui_nz !== 0) begin n_bad++; $display("FAIL glitch_code: got %0d nonzero cycles, want 0", ui_nz); end
    n_cmp++;
    if (press_cnt !== 8'd1) begin n_bad++; $display("FAIL glitch_cnt: got %0d, want 1", press_cnt); end
  endtask

  task automatic test_multi();
    raw_btn = 3'b110;
    repeat (20) tick();
    n_cmp++;
    if (user_input !== 3'd2 || err_multi !== 1'b1) begin
      n_bad++;
      $display("FAIL multi_press: got ui=%0d err=%0b, want ui=2 err=1", user_input, err_multi);
    end
    raw_btn = 3'b000;
    repeat (20) tick();
    n_cmp++;
    if (user_input !== 3'd0 || err_multi !== 1'b1) begin
      n_bad++;
      $display("FAIL multi_sticky: got ui=%0d err=%0b, want ui=0 err=1", user_input, err_multi);
    end
  endtask

  task automatic test_lockout();
    int nstb = 0;
    int ui_bad = 0;
    int first_zero = -1;
    raw_btn = 3'b001;
    repeat (LAT + 2) tick();
    raw_btn = 3'b100;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (cmd_strobe !== 1'b0) nstb++;
      if (user_input !== 3'd1) ui_bad++;
    end
    n_cmp++;
    if (nstb !== 0) begin n_bad++; $display("FAIL lockout_strobe: got %0d strobes, want 0", nstb); end
    n_cmp++;
    if (ui_bad !== 0) begin n_bad++; $display("FAIL lockout_code: got %0d cycles not 1, want 0", ui_bad); end
    raw_btn = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first_zero < 0 && user_input === 3'd0) first_zero = k;
    end
    n_cmp++;
    if (first_zero !== LAT) begin n_bad++; $display("FAIL release_latency: got %0d, want %0d", first_zero, LAT); end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    int first = -1;
    raw_btn = 3'b001;
    repeat (LAT + 3) tick();
    n_cmp++;
    if (user_input !== 3'd1) begin n_bad++; $display("FAIL hold_before_rst: got %0d, want 1", user_input); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (user_input !== 3'd0 || cmd_strobe !== 1'b0 || err_multi !== 1'b0 || press_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got ui=%0d strobe=%0b err=%0b cnt=%0d, want all 0",
               user_input, cmd_strobe, err_multi, press_cnt);
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (first < 0 && cmd_strobe === 1'b1) first = k;
    end
    n_cmp++;
    if (first !== LAT) begin n_bad++; $display("FAIL repress_latency: got %0d, want %0d", first, LAT); end
    n_cmp++;
    if (press_cnt !== 8'd1) begin n_bad++; $display("FAIL repress_cnt: got %0d, want 1", press_cnt); end
    raw_btn = 3'b000;
    repeat (20) tick();
  endtask

  task automatic test_saturation();
    int nstb = 0;
    for (int p = 0; p < 260; p++) begin
      raw_btn = 3'b001 << $urandom_range(0, 2);
      for (int k = 0; k < 2 * HALF; k++) begin
        if (k == HALF) raw_btn = 3'b000;
        tick();
        if (cmd_strobe === 1'b1) nstb++;
        n_cmp++;
        if (user_input !== m_ui || cmd_strobe !== m_strobe || err_multi !== m_err || press_cnt !== m_cnt) begin
          n_bad++;
          $display("FAIL sat_model p=%0d: got ui=%0d stb=%0b err=%0b cnt=%0d, want ui=%0d stb=%0b err=%0b cnt=%0d",
                   p, user_input, cmd_strobe, err_multi, press_cnt, m_ui, m_strobe, m_err, m_cnt);
        end
      end
    end
    repeat (HALF) tick();
    n_cmp++;
    if (nstb !== 260) begin n_bad++; $display("FAIL sat_strobes: got %0d, want 260", nstb); end
    n_cmp++;
    if (press_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_cnt: got %0d, want 255", press_cnt); end
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 80; s++) begin
      int len;
      raw_btn = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        tick();
        n_cmp++;
        if (user_input !== m_ui || cmd_strobe !== m_strobe || err_multi !== m_err || press_cnt !== m_cnt) begin
          n_bad++;
          $display("FAIL rand_model s=%0d: got ui=%0d stb=%0b err=%0b cnt=%0d, want ui=%0d stb=%0b err=%0b cnt=%0d",
                   s, user_input, cmd_strobe, err_multi, press_cnt, m_ui, m_strobe, m_err, m_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_multi();
    test_lockout();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
